// File: rtl/alu_result_stage.sv
// Registered result stage: picks the function-code result, owns the HI/LO product
// registers, interlocks MFHI/MFLO against an in-flight MULTU and hands results downstream.
module alu_result_stage #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [5:0]           Signal,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic [WIDTH-1:0]     shift_result,
   input  logic                 mul_busy,
   input  logic                 mul_done,
   input  logic [2*WIDTH-1:0]   mul_product,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     dataOut,
   output logic [WIDTH-1:0]     hi_out,
   output logic [WIDTH-1:0]     lo_out
);

   localparam logic [5:0] OP_AND   = 6'd36;
   localparam logic [5:0] OP_OR    = 6'd37;
   localparam logic [5:0] OP_ADD   = 6'd32;
   localparam logic [5:0] OP_SUB   = 6'd34;
   localparam logic [5:0] OP_SLT   = 6'd42;
   localparam logic [5:0] OP_SLL   = 6'd0;
   localparam logic [5:0] OP_MULTU = 6'd25;
   localparam logic [5:0] OP_MFHI  = 6'd16;
   localparam logic [5:0] OP_MFLO  = 6'd18;

   typedef enum logic [1:0] {IDLE, HOLD, STALL} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q, data_nxt;
   logic [WIDTH-1:0] hi_q, hi_nxt;
   logic [WIDTH-1:0] lo_q, lo_nxt;
   logic             mul_pending, pending_nxt;
   logic             want_hi, want_hi_nxt;
   logic             xfer;
   logic             read_hi;
   logic [WIDTH-1:0] prod_hi, prod_lo;

   // The multiplier's own busy flag is redundant with mul_pending here.
   logic unused_mul_busy;
   assign unused_mul_busy = mul_busy;

   assign prod_hi = mul_product[2*WIDTH-1:WIDTH];
   assign prod_lo = mul_product[WIDTH-1:0];

   assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
   assign xfer      = in_valid && in_ready;
   assign read_hi   = (Signal == OP_MFHI);
   assign out_valid = (state == HOLD);
   assign dataOut   = data_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt   = state;
      data_nxt    = data_q;
      hi_nxt      = hi_q;
      lo_nxt      = lo_q;
      pending_nxt = mul_pending;
      want_hi_nxt = want_hi;

      if (mul_done) begin
         hi_nxt      = prod_hi;
         lo_nxt      = prod_lo;
         pending_nxt = 1'b0;
      end

      if (xfer) begin
         state_nxt = HOLD;
         case (Signal)
            OP_MULTU: begin
               pending_nxt = 1'b1;
               state_nxt   = IDLE;
            end
            OP_MFHI, OP_MFLO: begin
               if (mul_done) begin
                  data_nxt = read_hi ? prod_hi : prod_lo;
               end else if (mul_pending) begin
                  state_nxt   = STALL;
                  want_hi_nxt = read_hi;
               end else begin
                  data_nxt = read_hi ? hi_q : lo_q;
               end
            end
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: data_nxt = alu_result;
            OP_SLL:                                data_nxt = shift_result;
            default:                               data_nxt = '0;
         endcase
      end else if (state == HOLD && out_ready) begin
         state_nxt = IDLE;
      end else if (state == STALL && mul_done) begin
         data_nxt  = want_hi ? prod_hi : prod_lo;
         state_nxt = HOLD;
      end
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         data_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         mul_pending <= 1'b0;
         want_hi     <= 1'b0;
      end else begin
         state       <= state_nxt;
         data_q      <= data_nxt;
         hi_q        <= hi_nxt;
         lo_q        <= lo_nxt;
         mul_pending <= pending_nxt;
         want_hi     <= want_hi_nxt;
      end
   end

endmodule
